// File: rtl/rand_range_picker.sv
// rand_range_picker
// Bounded random value generator placed after a 16-bit LFSR. On a request it
// steps the LFSR once, captures the new word, and reduces it modulo RANGE
// with a bit-serial restoring division of fixed length (IN_W cycles).
// The result is presented on value with a one-cycle valid pulse.
//
// Optional feature: define NO_REPEAT_EN so that two consecutive results are
// never equal. A result that matches the previous delivery is bumped to the
// next value, wrapping RANGE-1 to 0.
module rand_range_picker #(
    parameter int RANGE = 12,
    parameter int OUT_W = 4,
    parameter int IN_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic [IN_W-1:0]  lfsr_in,
    output logic             lfsr_ce,
    output logic             busy,
    output logic             valid,
    output logic [OUT_W-1:0] value
);

    localparam int               CNT_W    = $clog2(IN_W);
    localparam logic [OUT_W+1:0] RANGE_T  = (OUT_W+2)'(RANGE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_W - 1);
`ifdef NO_REPEAT_EN
    localparam logic [OUT_W-1:0] RANGE_M1 = OUT_W'(RANGE - 1);
`endif

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        CAPTURE,
        DIVIDE,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [IN_W-1:0]  dividend;
    logic [OUT_W:0]   rem;
    logic [CNT_W-1:0] count;

    logic [OUT_W+1:0] trial;
    logic             trial_ge;
    logic [OUT_W:0]   rem_next;
    logic [OUT_W-1:0] result;
    logic             last_step;

`ifdef NO_REPEAT_EN
    logic [OUT_W-1:0] prev;
    logic             prev_valid;
`endif

    // State register; reset aborts any computation in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus Moore outputs taken from the registered state.
    always_comb begin
        state_next = state;
        lfsr_ce    = 1'b0;
        busy       = 1'b1;
        valid      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                lfsr_ce    = 1'b1;
                state_next = CAPTURE;
            end
            CAPTURE: begin
                state_next = DIVIDE;
            end
            DIVIDE: begin
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                valid      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One restoring-division step: shift in the dividend MSB, subtract RANGE if it fits.
    // The remainder never exceeds RANGE-1, so the extra trial bit only widens the compare.
    always_comb begin
        trial     = {rem, dividend[IN_W-1]};
        trial_ge  = (trial >= RANGE_T);
        rem_next  = trial_ge ? (OUT_W+1)'(trial - RANGE_T) : trial[OUT_W:0];
        last_step = (count == LAST_CNT);
    end

    // Value to deliver from the final remainder, with the optional no-repeat bump.
    always_comb begin
        result = rem_next[OUT_W-1:0];
`ifdef NO_REPEAT_EN
        if (prev_valid && (rem_next == {1'b0, prev})) begin
            result = (rem_next[OUT_W-1:0] == RANGE_M1) ? '0
                                                        : rem_next[OUT_W-1:0] + OUT_W'(1);
        end
`endif
    end

    // Datapath: capture the word, iterate the division, register the result entering DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dividend   <= '0;
            rem        <= '0;
            count      <= '0;
            value      <= '0;
`ifdef NO_REPEAT_EN
            prev       <= '0;
            prev_valid <= 1'b0;
`endif
        end else begin
            case (state)
                CAPTURE: begin
                    dividend <= lfsr_in;
                    rem      <= '0;
                    count    <= '0;
                end
                DIVIDE: begin
                    dividend <= {dividend[IN_W-2:0], trial_ge};
                    rem      <= rem_next;
                    count    <= count + CNT_W'(1);
                    if (last_step) begin
                        value <= result;
`ifdef NO_REPEAT_EN
                        prev       <= result;
                        prev_valid <= 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
